uart_receive: RTL and testbench

Serial-to-parallel UART receiver: recovers 8-bit frames (start bit, 8 data bits LSB first, optional parity, one stop bit) from an asynchronous `rx` line and presents each byte on a held valid/ack handshake. Downstream counterpart of the transmit stage: it consumes the line the transmitter drives and feeds received bytes to the game-control logic, using the same bit-period parameter.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_receive.sv | 182 ++++++++++++++++++
 tb/tb_uart_receive.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit stages.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RESET_LEVEL so an idle-high line does not glitch low out of reset.
module uart_sync2
    import uart_pkg::*;
#(
    parameter logic RESET_LEVEL = UART_IDLE_LEVEL
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to add the parity bit and the parity_error output.
module uart_receive
    import uart_pkg::*;
#(
    parameter int clockperbit = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rxdata,
    output logic                      rxvalid,
    input  logic                      rxack,
    output logic                      frame_error,
    output logic                      overrun,
`ifdef UART_RX_PARITY_EN
    output logic                      parity_error,
`endif
    input  logic                      clear_err
);

    localparam int              CNT_W    = $clog2(clockperbit);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(clockperbit / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(clockperbit - 1);

    rx_state_t                 state, state_next;
    logic                      rx_s;
    logic [CNT_W-1:0]          cnt, cnt_value;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shift;

    logic cnt_load, cnt_dec, idx_clear, idx_inc;
    logic data_sample, byte_done, stop_bad;

    uart_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_next;
    end

`ifdef UART_RX_PARITY_EN
    logic parity_sample;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_value   = FULL_BIT;
        cnt_dec     = 1'b0;
        idx_clear   = 1'b0;
        idx_inc     = 1'b0;
        data_sample = 1'b0;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_sample = 1'b0;
`endif
        unique case (state)
            RX_IDLE: begin
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_next = RX_START;
                    cnt_load   = 1'b1;
                    cnt_value  = HALF_BIT;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_dec = 1'b1;
                end else if (rx_s == UART_IDLE_LEVEL) begin
                    state_next = RX_IDLE;  // glitch shorter than half a bit
                end else begin
                    state_next = RX_DATA;
                    cnt_load   = 1'b1;
                    idx_clear  = 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    data_sample = 1'b1;
                    cnt_load    = 1'b1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    parity_sample = 1'b1;
                    cnt_load      = 1'b1;
                    state_next    = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_dec = 1'b1;
                end else if (rx_s == UART_IDLE_LEVEL) begin
                    byte_done  = 1'b1;
                    state_next = RX_IDLE;
                end else begin
                    stop_bad   = 1'b1;
                    state_next = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_s == UART_IDLE_LEVEL) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            if (cnt_load)     cnt <= cnt_value;
            else if (cnt_dec) cnt <= cnt - CNT_W'(1);

            if (idx_clear)    idx <= '0;
            else if (idx_inc) idx <= idx + 3'd1;

            if (data_sample)  shift[idx] <= rx_s;
        end
    end

    // A completing byte is accepted if the holding register is free or is
    // being acknowledged in the same cycle; otherwise it is dropped as overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxdata      <= '0;
            rxvalid     <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            if (byte_done && (!rxvalid || rxack)) begin
                rxdata  <= shift;
                rxvalid <= 1'b1;
            end else if (rxvalid && rxack) begin
                rxvalid <= 1'b0;
            end

            if (byte_done && rxvalid && !rxack) overrun <= 1'b1;
            else if (clear_err)                 overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_bad   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (parity_sample) parity_bad <= (rx_s != even_parity(shift));
            parity_error <= byte_done && parity_bad;
        end
    end
`endif

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: vector table, hand-written corner
// sequences, and randomized frames with baud skew against a frame-level model.
module tb_uart_receive;

    localparam int CPB   = 16;
    localparam int CLK_T = 10;
    localparam int BIT_T = CPB * CLK_T;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rxack = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       frame_error;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       bad_parity = 1'b0;
`endif

    uart_receive #(.clockperbit(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .rxdata       (rxdata),
        .rxvalid      (rxvalid),
        .rxack        (rxack),
        .frame_error  (frame_error),
        .overrun      (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .clear_err    (clear_err)
    );

    always #(CLK_T / 2) clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int fe_count = 0;
    int pe_count = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_error) fe_count++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_count++;
`endif
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one frame on rx with the given bit time; a low stop bit is
    // followed by 40 more cycles of low line before returning idle.
    task automatic send_frame(input logic [7:0] b, input logic stop_level, input int bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ bad_parity;
        #(bit_t);
`endif
        rx = stop_level;
        #(bit_t);
        if (!stop_level) #(40 * CLK_T);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = rxvalid;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            got = rxvalid;
        end
    endtask

    task automatic do_ack();
        @(negedge clock);
        rxack = 1'b1;
        @(negedge clock);
        rxack = 1'b0;
        check("ack_clears_valid", rxvalid, 1'b0);
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        bit got;
        wait_valid(4 * CPB, got);
        check({name, "_valid"}, got, 1'b1);
        check({name, "_data"}, rxdata, exp);
        if (got) do_ack();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit         got;
        int         fe0, pe0, c0, lat, bt;
        logic [9:0] frame;
        logic [7:0] exp_q[$];
        logic [7:0] exp_b;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 1};
        vecs[3] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 8'h00, 1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};

        // Reset state
        #(3 * CLK_T + 2);
        check("reset_rxdata", rxdata, 8'h00);
        check("reset_rxvalid", rxvalid, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // A5 with latency measurement from start edge to rxvalid
        c0 = cyc;
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, BIT_T);
            begin
                for (int i = 0; i < 300 && lat < 0; i++) begin
                    @(negedge clock);
                    if (rxvalid) lat = cyc - c0;
                end
            end
        join
        check("a5_latency_in_window", (lat >= 150 && lat <= 170), 1'b1);
        check("a5_data", rxdata, 8'hA5);
        repeat (20) @(negedge clock);
        check("valid_held_without_ack", rxvalid, 1'b1);
        do_ack();

        // Table-driven frames
        foreach (vecs[k]) begin
            fe0 = fe_count;
            @(negedge clock);
            send_frame(vecs[k].data, vecs[k].stop, BIT_T);
            wait_valid(3 * CPB, got);
            check($sformatf("vec%0d_valid", k), got, vecs[k].exp_valid);
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d_data", k), rxdata, vecs[k].exp_data);
                do_ack();
            end
            check($sformatf("vec%0d_fe_pulses", k), fe_count - fe0, vecs[k].exp_fe);
        end

        // Short 5-cycle glitch is a false start
        @(negedge clock);
        rx = 1'b0;
        repeat (5) @(negedge clock);
        rx = 1'b1;
        wait_valid(3 * CPB, got);
        check("glitch_no_valid", got, 1'b0);
        @(negedge clock);
        send_frame(8'h3C, 1'b1, BIT_T);
        expect_byte("after_glitch", 8'h3C);

        // Overrun: two bytes without ack
        @(negedge clock);
        send_frame(8'h11, 1'b1, BIT_T);
        #(BIT_T);
        send_frame(8'h22, 1'b1, BIT_T);
        repeat (2 * CPB) @(negedge clock);
        check("overrun_keeps_old", rxdata, 8'h11);
        check("overrun_valid", rxvalid, 1'b1);
        check("overrun_set", overrun, 1'b1);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        check("overrun_cleared", overrun, 1'b0);

        // Reset during data bit 4 of FF while the old byte is still pending
        fork
            send_frame(8'hFF, 1'b1, BIT_T);
            begin
                #(BIT_T * 5 + BIT_T / 2);
                reset = 1'b0;
                #1;
                check("midreset_rxdata", rxdata, 8'h00);
                check("midreset_rxvalid", rxvalid, 1'b0);
                check("midreset_overrun", overrun, 1'b0);
                check("midreset_frame_error", frame_error, 1'b0);
                #(3 * CLK_T);
                reset = 1'b1;
            end
        join
        wait_valid(3 * CPB, got);
        check("midreset_no_valid", got, 1'b0);
        @(negedge clock);
        send_frame(8'h81, 1'b1, BIT_T);
        expect_byte("after_reset", 8'h81);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_count;
        bad_parity = 1'b1;
        @(negedge clock);
        send_frame(8'h07, 1'b1, BIT_T);
        expect_byte("parity_bad", 8'h07);
        check("parity_bad_pulse", pe_count - pe0, 1);
        pe0 = pe_count;
        bad_parity = 1'b0;
        @(negedge clock);
        send_frame(8'h07, 1'b1, BIT_T);
        expect_byte("parity_good", 8'h07);
        check("parity_good_no_pulse", pe_count - pe0, 0);
`else
        pe0 = pe_count;
        check("no_parity_pulses", pe0, 0);
`endif

        // Randomized frames with +/-2% baud skew against a frame-level model
        for (int n = 0; n < 24; n++) begin
            frame = {($urandom_range(0, 7) != 0), 8'($urandom), 1'b0};
            bt    = BIT_T - 3 + int'($urandom_range(0, 6));
            if (frame[9]) exp_q.push_back(frame[8:1]);
            fe0 = fe_count;
            @(negedge clock);
            send_frame(frame[8:1], frame[9], bt);
            wait_valid(3 * CPB, got);
            check($sformatf("rand%0d_valid", n), got, frame[9]);
            if (got && exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check($sformatf("rand%0d_data", n), rxdata, exp_b);
                do_ack();
            end
            check($sformatf("rand%0d_fe", n), fe_count - fe0, {31'd0, ~frame[9]});
            #(bt * int'($urandom_range(0, 2)));
        end
        check("rand_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
